// File: rtl/matrix_frame_tx_pkg.sv
// Shared types and defaults for the LED-matrix frame transmitter.
package matrix_pkg;

  localparam int WORD_W      = 16;
  localparam int FRAME_WORDS = 256;
  localparam int MEM_LAT     = 2;
  localparam int CLK_DIV     = 4;
  localparam int LATCH_CYC   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_frame_tx_ser_shifter.sv
// MSB-first serialiser: ser_clk half-period of DIV cycles, bit_done on the falling edge after the last rise.
module ser_shifter
  import matrix_pkg::*;
#(
  parameter int W   = 16,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] data,
  output logic         ser_clk,
  output logic         ser_data,
  output logic         bit_done
);

  localparam int DW = cnt_w(DIV);
  localparam int BW = cnt_w(W);
  localparam logic [DW-1:0] DIV_TC = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_TC = BW'(W - 1);

  logic [W-1:0]  shreg_q, shreg_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          ser_clk_q, ser_clk_d;
  logic          tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      ser_clk_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      ser_clk_q <= ser_clk_d;
    end
  end

  always_comb begin
    shreg_d   = shreg_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    ser_clk_d = ser_clk_q;
    tick      = shift_en && (div_cnt_q == '0);
    bit_done  = tick && ser_clk_q && (bit_cnt_q == '0);
    if (load) begin
      shreg_d   = data;
      div_cnt_d = DIV_TC;
      bit_cnt_d = BIT_TC;
      ser_clk_d = 1'b0;
    end else if (shift_en) begin
      if (tick) begin
        div_cnt_d = DIV_TC;
        ser_clk_d = ~ser_clk_q;
        // falling edge: the driver has taken the current bit, expose the next one
        if (ser_clk_q) begin
          shreg_d = shreg_q << 1;
          if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - BW'(1);
        end
      end else begin
        div_cnt_d = div_cnt_q - DW'(1);
      end
    end
  end

  assign ser_clk  = ser_clk_q;
  assign ser_data = shreg_q[W-1];

endmodule

// File: rtl/matrix_frame_tx.sv
// Frame sequencer: requests each matrix word, waits for the memory, serialises it and latches it.
module matrix_frame_tx #(
  parameter int WORD_W      = matrix_pkg::WORD_W,
  parameter int FRAME_WORDS = matrix_pkg::FRAME_WORDS,
  parameter int MEM_LAT     = matrix_pkg::MEM_LAT,
  parameter int CLK_DIV     = matrix_pkg::CLK_DIV,
  parameter int LATCH_CYC   = matrix_pkg::LATCH_CYC
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [WORD_W-1:0]                          mem_data,
  output logic                                       word_req,
  output logic                                       ser_data,
  output logic                                       ser_clk,
  output logic                                       ser_latch,
  output logic                                       busy,
  output logic                                       frame_done,
  output logic [matrix_pkg::cnt_w(FRAME_WORDS)-1:0]  word_idx
);

  import matrix_pkg::*;

  localparam int IW = cnt_w(FRAME_WORDS);
  localparam int LW = cnt_w(MEM_LAT);
  localparam int CW = cnt_w(LATCH_CYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);
  localparam logic [LW-1:0] LAT_TC   = LW'(MEM_LAT - 1);
  localparam logic [CW-1:0] LCH_TC   = CW'(LATCH_CYC - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] word_idx_q, word_idx_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [CW-1:0] lch_cnt_q, lch_cnt_d;
  logic          sh_load, sh_en, bit_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      lat_cnt_q  <= '0;
      lch_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      lat_cnt_q  <= lat_cnt_d;
      lch_cnt_q  <= lch_cnt_d;
    end
  end

  // Counters load terminal-1 so WAIT lasts MEM_LAT cycles and LATCH lasts LATCH_CYC cycles.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    lat_cnt_d  = lat_cnt_q;
    lch_cnt_d  = lch_cnt_q;
    sh_load    = 1'b0;
    sh_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          word_idx_d = '0;
          lat_cnt_d  = LAT_TC;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) state_d = ST_LOAD;
        else                 lat_cnt_d = lat_cnt_q - LW'(1);
      end
      ST_LOAD: begin
        sh_load = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sh_en = 1'b1;
        if (bit_done) begin
          lch_cnt_d = LCH_TC;
          state_d   = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (lch_cnt_q != '0)            lch_cnt_d = lch_cnt_q - CW'(1);
        else if (word_idx_q == LAST_IDX) state_d = ST_DONE;
        else                            state_d = ST_NEXT;
      end
      ST_NEXT: begin
        word_idx_d = word_idx_q + IW'(1);
        lat_cnt_d  = LAT_TC;
        state_d    = ST_WAIT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  ser_shifter #(
    .W   (WORD_W),
    .DIV (CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst      (reset),
    .load     (sh_load),
    .shift_en (sh_en),
    .data     (mem_data),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .bit_done (bit_done)
  );

  assign word_req   = (state_q == ST_NEXT);
  assign ser_latch  = (state_q == ST_LATCH);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign word_idx   = word_idx_q;

endmodule

// File: tb/tb_matrix_frame_tx.sv
// Bench for matrix_frame_tx: a fast full-frame instance (b) and a one-word default-timing instance (c).
module tb_matrix_frame_tx;

  localparam int WW      = 16;
  localparam int LC      = 2;
  localparam int ML_B    = 1;
  localparam int CD_B    = 1;
  localparam int FW_B    = 256;
  localparam int ML_C    = 2;
  localparam int CD_C    = 4;
  localparam int PER_B   = ML_B + 1 + 2 * CD_B * WW + LC + 1;
  localparam int FRAME_B = FW_B * PER_B - 1;
  localparam int FRAME_C = ML_C + 1 + 2 * CD_C * WW + LC;
  localparam int NBUF    = 2048;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_b = 1'b0;
  logic start_c = 1'b0;
  logic ext_pulse = 1'b0;
  int   mode_b = 0;

  logic [15:0] mem_data_b, mem_data_c, word_c_val;
  logic [15:0] rand_mem [256];
  logic [7:0]  addr_b;

  logic word_req_b, ser_data_b, ser_clk_b, ser_latch_b, busy_b, frame_done_b;
  logic word_req_c, ser_data_c, ser_clk_c, ser_latch_c, busy_c, frame_done_c;
  logic [7:0] word_idx_b;
  logic [0:0] word_idx_c;

  always #5 clk = ~clk;

  matrix_frame_tx #(.WORD_W(WW), .FRAME_WORDS(FW_B), .MEM_LAT(ML_B), .CLK_DIV(CD_B), .LATCH_CYC(LC)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .mem_data(mem_data_b),
    .word_req(word_req_b), .ser_data(ser_data_b), .ser_clk(ser_clk_b), .ser_latch(ser_latch_b),
    .busy(busy_b), .frame_done(frame_done_b), .word_idx(word_idx_b));

  matrix_frame_tx #(.WORD_W(WW), .FRAME_WORDS(1), .MEM_LAT(ML_C), .CLK_DIV(CD_C), .LATCH_CYC(LC)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .mem_data(mem_data_c),
    .word_req(word_req_c), .ser_data(ser_data_c), .ser_clk(ser_clk_c), .ser_latch(ser_latch_c),
    .busy(busy_c), .frame_done(frame_done_c), .word_idx(word_idx_c));

  // external matrix address counter, advanced by word_req or by the bench between frames
  always @(posedge clk or posedge reset)
    if (reset) addr_b <= 8'd0;
    else if (word_req_b || ext_pulse) addr_b <= addr_b + 8'd1;

  assign mem_data_b = (mode_b == 0) ? 16'hA5C3 : (mode_b == 1) ? {8'h00, addr_b} : rand_mem[addr_b];
  assign mem_data_c = word_c_val;

  // ---------------- passive monitor (index 0 = b, 1 = c) ----------------
  logic sclk [2], sdat [2], slat [2], sreq [2], sdone [2], sbusy [2];
  assign sclk[0] = ser_clk_b;   assign sclk[1] = ser_clk_c;
  assign sdat[0] = ser_data_b;  assign sdat[1] = ser_data_c;
  assign slat[0] = ser_latch_b; assign slat[1] = ser_latch_c;
  assign sreq[0] = word_req_b;  assign sreq[1] = word_req_c;
  assign sdone[0] = frame_done_b; assign sdone[1] = frame_done_c;
  assign sbusy[0] = busy_b;     assign sbusy[1] = busy_c;

  int cyc = 0;
  logic prev_clk [2], prev_dat [2], prev_lat [2], prev_busy [2];
  logic [15:0] cur_w [2];
  logic [15:0] words [2][NBUF];
  int lat_t [2][NBUF];
  int nbits [2], last_rise [2], nwords [2], n_req [2], n_lcyc [2], n_done [2], done_t [2], busy_t [2];
  int bad_stable [2], bad_period [2], bad_nbits [2];

  function automatic int half_of(input int i);
    return (i == 0) ? CD_B : CD_C;
  endfunction

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        nbits[i] <= 0;
      end else begin
        if (sclk[i] && !prev_clk[i]) begin
          if (sdat[i] !== prev_dat[i]) bad_stable[i] <= bad_stable[i] + 1;
          if (nbits[i] > 0 && (cyc - last_rise[i]) != 2 * half_of(i)) bad_period[i] <= bad_period[i] + 1;
          last_rise[i] <= cyc;
          cur_w[i] <= {cur_w[i][14:0], sdat[i]};
          nbits[i] <= nbits[i] + 1;
        end
        if (slat[i] && !prev_lat[i]) begin
          if (nbits[i] != WW) bad_nbits[i] <= bad_nbits[i] + 1;
          if (nwords[i] < NBUF) begin
            words[i][nwords[i]] <= cur_w[i];
            lat_t[i][nwords[i]] <= cyc;
          end
          nwords[i] <= nwords[i] + 1;
          nbits[i] <= 0;
        end
        if (slat[i]) n_lcyc[i] <= n_lcyc[i] + 1;
        if (sreq[i]) n_req[i] <= n_req[i] + 1;
        if (sdone[i]) begin
          n_done[i] <= n_done[i] + 1;
          done_t[i] <= cyc;
        end
        if (sbusy[i] && !prev_busy[i]) busy_t[i] <= cyc;
      end
      prev_clk[i]  <= sclk[i];
      prev_dat[i]  <= sdat[i];
      prev_lat[i]  <= slat[i];
      prev_busy[i] <= sbusy[i];
    end
  end

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_done[i] < target && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(n_done[i] >= target), 64'd1);
  endtask

  function automatic logic [15:0] exp_word(input int k);
    if (mode_b == 0) return 16'hA5C3;
    if (mode_b == 1) return 16'(k);
    return rand_mem[k];
  endfunction

  // Runs one frame on instance b; returns with the bench inside the frame_done cycle.
  task automatic frame_b(input string tag, input bit mid_start, output int w0);
    int r0, l0, d0, bad_w, bad_p;
    w0 = nwords[0]; r0 = n_req[0]; l0 = n_lcyc[0]; d0 = n_done[0];
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    chk({tag, " busy after start"}, 64'(busy_b), 64'd1);
    if (mid_start) begin
      tick(300);
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
    end
    wait_done(0, d0 + 1, FRAME_B + 50, {tag, " frame_done reached"});
    chk({tag, " frame cycles"}, 64'(done_t[0] - busy_t[0]), 64'(FRAME_B));
    chk({tag, " words latched"}, 64'(nwords[0] - w0), 64'(FW_B));
    chk({tag, " word_req pulses"}, 64'(n_req[0] - r0), 64'(FW_B - 1));
    chk({tag, " latch-high cycles"}, 64'(n_lcyc[0] - l0), 64'(FW_B * LC));
    chk({tag, " latch to done"}, 64'(done_t[0] - lat_t[0][w0 + FW_B - 1]), 64'(LC));
    chk({tag, " counter at done"}, 64'(addr_b), 64'(FW_B - 1));
    bad_w = 0;
    bad_p = 0;
    for (int k = 0; k < FW_B; k++) begin
      if (words[0][w0 + k] !== exp_word(k)) bad_w++;
      if (k > 0 && (lat_t[0][w0 + k] - lat_t[0][w0 + k - 1]) != PER_B) bad_p++;
    end
    chk({tag, " word 0 value"}, 64'(words[0][w0]), 64'(exp_word(0)));
    chk({tag, " mismatching words"}, 64'(bad_w), 64'd0);
    chk({tag, " bad word periods"}, 64'(bad_p), 64'd0);
  endtask

  task automatic wrap_counter();
    ext_pulse = 1'b1;
    tick(1);
    ext_pulse = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wa, wb, diff, k, w0c, r0c;
    logic [15:0] c_first;
    for (int a = 0; a < 256; a++) rand_mem[a] = 16'($urandom);
    word_c_val = 16'($urandom);

    #2 reset = 1'b1;
    tick(2);
    chk("rst word_req", 64'(word_req_b), 64'd0);
    chk("rst ser_data", 64'(ser_data_b), 64'd0);
    chk("rst ser_clk", 64'(ser_clk_b), 64'd0);
    chk("rst ser_latch", 64'(ser_latch_b), 64'd0);
    chk("rst busy", 64'(busy_b), 64'd0);
    chk("rst frame_done", 64'(frame_done_b), 64'd0);
    chk("rst word_idx", 64'(word_idx_b), 64'd0);
    chk("rst c outputs", 64'({word_req_c, ser_data_c, ser_clk_c, ser_latch_c, busy_c, frame_done_c, word_idx_c}), 64'd0);
    reset = 1'b0;
    tick(2);

    // fixed pattern frame
    mode_b = 0;
    frame_b("fixed", 1'b0, wa);
    wrap_counter();
    chk("fixed busy after done", 64'(busy_b), 64'd0);
    chk("fixed done is one cycle", 64'(frame_done_b), 64'd0);
    chk("fixed counter wrapped", 64'(addr_b), 64'd0);

    // data = address, with a start issued mid-frame
    mode_b = 1;
    frame_b("addr", 1'b1, wa);
    wrap_counter();
    chk("addr no queued frame", 64'(busy_b), 64'd0);
    chk("addr counter wrapped", 64'(addr_b), 64'd0);

    // random contents, back-to-back, with a start coinciding with frame_done
    mode_b = 2;
    frame_b("rand1", 1'b0, wa);
    ext_pulse = 1'b1;
    start_b = 1'b1;
    tick(1);
    ext_pulse = 1'b0;
    start_b = 1'b0;
    chk("start at done ignored", 64'(busy_b), 64'd0);
    frame_b("rand2", 1'b0, wb);
    diff = 0;
    for (int j = 0; j < FW_B; j++) if (words[0][wa + j] !== words[0][wb + j]) diff++;
    chk("back-to-back streams differ", 64'(diff), 64'd0);
    wrap_counter();

    // reset in the middle of word 7's shift
    mode_b = 1;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    k = 0;
    while (!(word_idx_b == 8'd7 && ser_clk_b) && k < 2000) begin
      tick(1);
      k++;
    end
    chk("reached word 7 shift", 64'(word_idx_b == 8'd7 && ser_clk_b), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid reset outputs", 64'({word_req_b, ser_data_b, ser_clk_b, ser_latch_b, frame_done_b}), 64'd0);
    chk("mid reset busy", 64'(busy_b), 64'd0);
    chk("mid reset word_idx", 64'(word_idx_b), 64'd0);
    chk("mid reset counter", 64'(addr_b), 64'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    frame_b("after reset", 1'b0, wa);
    wrap_counter();

    // single-word frame at default timing; mem_data changes after LOAD must not matter
    w0c = nwords[1];
    r0c = n_req[1];
    c_first = word_c_val;
    start_c = 1'b1;
    tick(1);
    start_c = 1'b0;
    tick(20);
    word_c_val = ~c_first ^ 16'($urandom_range(0, 255));
    wait_done(1, 1, FRAME_C + 50, "single frame_done reached");
    chk("single frame cycles", 64'(done_t[1] - busy_t[1]), 64'(FRAME_C));
    chk("single words latched", 64'(nwords[1] - w0c), 64'd1);
    chk("single word_req pulses", 64'(n_req[1] - r0c), 64'd0);
    chk("single word value", 64'(words[1][w0c]), 64'(c_first));
    chk("single latch-high cycles", 64'(n_lcyc[1]), 64'(LC));
    tick(1);
    chk("single busy after done", 64'(busy_c), 64'd0);

    chk("b data stable at ser_clk rise", 64'(bad_stable[0]), 64'd0);
    chk("b ser_clk period", 64'(bad_period[0]), 64'd0);
    chk("b bits per latch", 64'(bad_nbits[0]), 64'd0);
    chk("c data stable at ser_clk rise", 64'(bad_stable[1]), 64'd0);
    chk("c ser_clk period", 64'(bad_period[1]), 64'd0);
    chk("c bits per latch", 64'(bad_nbits[1]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
